mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_id_fifo.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/LSU memory port arbiter.
// Holds the default word width, the arbiter state encoding and the
// requester identifier used both for selection and in the in-order ID FIFO.
package mem_port_arbiter_pkg;

  localparam int WORD_WIDTH = 32;

  // Fetches always read a whole word, so the fetch side presents all lanes.
  localparam logic [3:0] FETCH_BE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } req_id_e;

endpackage

// File: rtl/mem_port_arbiter_id_fifo.sv
// id_fifo: small in-order FIFO of requester IDs for outstanding transactions.
// Ports: i_push/i_din write, i_pop/o_dout read (head visible combinationally),
//        o_full/o_empty status; asynchronous active-high reset empties it.
// A push while full is accepted only when a pop happens in the same cycle.
module id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  // Index width; a depth of 1 still gets a one-bit index so the ring has
  // two slots, of which at most one is ever occupied.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [2**AW];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [AW:0]      w_count;
  logic             w_do_push;
  logic             w_do_pop;

  // The extra wrap bit lets full and empty be told apart from the pointer difference.
  assign w_count   = r_wptr - r_rptr;
  assign o_empty   = (w_count == '0);
  assign o_full    = (w_count == DEPTH_L);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + ONE_L;
      if (w_do_pop)  r_rptr <= r_rptr + ONE_L;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (instr_*) and LSU (data_*).
// Ports: requester interfaces in, mem_* request/response to the shared memory,
//        resp_err_o flags a response with nothing outstanding.
// Round-robin pick in IDLE, locked while a presented request waits for mem_gnt_i;
// responses are steered from the head of an in-order ID FIFO with zero latency.
module mem_port_arbiter #(
  parameter int WORD_WIDTH      = mem_port_arbiter_pkg::WORD_WIDTH,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_req_i,
  input  logic [WORD_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [WORD_WIDTH-1:0] instr_rdata_o,
  input  logic                  data_req_i,
  input  logic [WORD_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [WORD_WIDTH-1:0] data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [WORD_WIDTH-1:0] data_rdata_o,
  output logic                  mem_req_o,
  output logic [WORD_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [WORD_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [WORD_WIDTH-1:0] mem_rdata_i,
  output logic                  resp_err_o
);

  import mem_port_arbiter_pkg::*;

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  req_id_e    r_last_grant;
  req_id_e    w_sel;
  req_id_e    w_head;
  logic       w_sel_req;
  logic       w_present;
  logic       w_granted;
  logic       w_pop;
  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic [0:0] w_push_id;
  logic [0:0] w_head_raw;

  // Selection: free choice only in IDLE, locked to the waiting requester otherwise.
  always_comb begin
    w_sel = INSTR;
    case (r_state)
      HOLD_I: w_sel = INSTR;
      HOLD_D: w_sel = DATA;
      default: begin
        if (instr_req_i && data_req_i) begin
          if (r_last_grant == DATA) w_sel = INSTR;
          else                      w_sel = DATA;
        end else if (data_req_i) begin
          w_sel = DATA;
        end
      end
    endcase
  end

  assign w_sel_req = (w_sel == INSTR) ? instr_req_i : data_req_i;
  // Reset gating keeps every output low for as long as rst is held.
  assign w_present = w_sel_req && !w_fifo_full && !rst;
  assign w_granted = w_present && mem_gnt_i;

  // A presented request that is not accepted locks the port to its owner;
  // a grant or a withdrawn request returns to free selection.
  always_comb begin
    w_state_nxt = IDLE;
    if (w_present && !mem_gnt_i) begin
      w_state_nxt = (w_sel == INSTR) ? HOLD_I : HOLD_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= DATA;
    end else begin
      r_state <= w_state_nxt;
      if (w_granted) r_last_grant <= w_sel;
    end
  end

  assign mem_req_o   = w_present;
  assign mem_addr_o  = !w_present ? '0 : ((w_sel == INSTR) ? instr_addr_i : data_addr_i);
  assign mem_we_o    = w_present && (w_sel == DATA) && data_we_i;
  assign mem_be_o    = !w_present ? 4'b0000 : ((w_sel == INSTR) ? FETCH_BE : data_be_i);
  assign mem_wdata_o = (w_present && (w_sel == DATA)) ? data_wdata_i : '0;

  assign instr_gnt_o = w_granted && (w_sel == INSTR);
  assign data_gnt_o  = w_granted && (w_sel == DATA);

  assign w_push_id = w_sel;
  assign w_pop     = !rst && mem_rvalid_i && !w_fifo_empty;

  id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_granted),
    .i_din   (w_push_id),
    .i_pop   (w_pop),
    .o_dout  (w_head_raw),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_head = req_id_e'(w_head_raw);

  assign instr_rvalid_o = w_pop && (w_head == INSTR);
  assign data_rvalid_o  = w_pop && (w_head == DATA);
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
  assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;

  // A response with nothing outstanding is dropped and only flagged.
  assign resp_err_o = !rst && mem_rvalid_i && w_fifo_empty;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized phase, all observed against a queue-based reference model.
module tb_mem_port_arbiter;

  localparam int W    = 32;
  localparam int MAXO = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_req;
  logic [W-1:0]  instr_addr;
  logic          data_req;
  logic [W-1:0]  data_addr;
  logic          data_we;
  logic [3:0]    data_be;
  logic [W-1:0]  data_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [W-1:0]  mem_rdata;

  logic          instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
  logic          mem_req_o, mem_we_o, resp_err_o;
  logic [W-1:0]  instr_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]    mem_be_o;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_WIDTH(W), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
    .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .resp_err_o(resp_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: requester ids 0 = fetch, 1 = LSU.
  int       m_q[$];
  int       m_last = 1;
  int       m_pend = -1;
  int       e_own;
  logic     e_mreq, e_mwe, e_ig, e_dg, e_irv, e_drv, e_err, e_push, e_pop;
  logic [W-1:0] e_maddr, e_mwd, e_ird, e_drd;
  logic [3:0]   e_mbe;

  // Observed values of the last stepped cycle, for directed checks.
  logic     o_ig, o_dg, o_irv, o_drv, o_err, o_mreq;
  logic [W-1:0] o_maddr, o_mwd, o_ird, o_drd;

  task automatic model_expect();
    int   own;
    logic oreq;
    e_mreq = 0; e_mwe = 0; e_ig = 0; e_dg = 0; e_irv = 0; e_drv = 0; e_err = 0;
    e_push = 0; e_pop = 0; e_maddr = '0; e_mwd = '0; e_ird = '0; e_drd = '0; e_mbe = '0;
    e_own = 0;
    if (!rst) begin
      if (m_pend >= 0)                 own = m_pend;
      else if (instr_req && data_req)  own = (m_last == 1) ? 0 : 1;
      else                             own = data_req ? 1 : 0;
      e_own  = own;
      oreq   = (own == 0) ? instr_req : data_req;
      e_mreq = oreq && (m_q.size() < MAXO);
      if (e_mreq) begin
        if (own == 0) begin
          e_maddr = instr_addr; e_mbe = 4'hF;
        end else begin
          e_maddr = data_addr; e_mbe = data_be; e_mwe = data_we; e_mwd = data_wdata;
        end
        e_push = mem_gnt;
        e_ig   = mem_gnt && (own == 0);
        e_dg   = mem_gnt && (own == 1);
      end
      if (mem_rvalid) begin
        if (m_q.size() == 0) e_err = 1;
        else begin
          e_pop = 1;
          if (m_q[0] == 0) begin e_irv = 1; e_ird = mem_rdata; end
          else             begin e_drv = 1; e_drd = mem_rdata; end
        end
      end
    end
  endtask

  task automatic model_commit();
    if (rst) begin
      m_q.delete(); m_last = 1; m_pend = -1;
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (e_push) begin m_q.push_back(e_own); m_last = e_own; end
      m_pend = (e_mreq && !mem_gnt) ? e_own : -1;
    end
  endtask

  // Inputs are set just after a rising edge; outputs are compared mid-cycle.
  task automatic step();
    @(negedge clk); #1;
    model_expect();
    check("mem_req", mem_req_o, e_mreq);
    check("mem_addr", mem_addr_o, e_maddr);
    check("mem_we", mem_we_o, e_mwe);
    check("mem_be", mem_be_o, e_mbe);
    check("mem_wdata", mem_wdata_o, e_mwd);
    check("instr_gnt", instr_gnt_o, e_ig);
    check("data_gnt", data_gnt_o, e_dg);
    check("instr_rvalid", instr_rvalid_o, e_irv);
    check("instr_rdata", instr_rdata_o, e_ird);
    check("data_rvalid", data_rvalid_o, e_drv);
    check("data_rdata", data_rdata_o, e_drd);
    check("resp_err", resp_err_o, e_err);
    o_ig = instr_gnt_o; o_dg = data_gnt_o; o_irv = instr_rvalid_o; o_drv = data_rvalid_o;
    o_err = resp_err_o; o_mreq = mem_req_o; o_maddr = mem_addr_o; o_mwd = mem_wdata_o;
    o_ird = instr_rdata_o; o_drd = data_rdata_o;
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_in();
    instr_req = 0; instr_addr = '0; data_req = 0; data_addr = '0; data_we = 0;
    data_be = '0; data_wdata = '0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_in(); rst = 1; step(); step(); rst = 0;
  endtask

  initial begin
    rst = 1; idle_in();
    #2;
    check("reset_mem_req", mem_req_o, 1'b0);
    do_reset();

    // Fetch-only stream, memory answers one cycle after each grant.
    for (int k = 0; k < 4; k++) begin
      idle_in();
      instr_req  = (k < 3);
      instr_addr = 32'(4 * k);
      mem_gnt    = 1;
      mem_rvalid = (k >= 1);
      mem_rdata  = 32'hA000_0000 + 32'(4 * (k - 1));
      step();
      check("s1_igrant", o_ig, (k < 3));
      check("s1_irvalid", o_irv, (k >= 1));
      if (k >= 1) check("s1_irdata", o_ird, 32'hA000_0000 + 32'(4 * (k - 1)));
      check("s1_dgrant", o_dg, 1'b0);
      check("s1_drvalid", o_drv, 1'b0);
    end

    // Both requesting every cycle: strict alternation, fetch first.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      idle_in();
      instr_req = 1; instr_addr = 32'h1000 + 32'(k);
      data_req  = 1; data_addr  = 32'h2000 + 32'(k);
      mem_gnt = 1; mem_rvalid = (k >= 1); mem_rdata = 32'(k);
      step();
      check("s2_igrant", o_ig, (k % 2 == 0));
      check("s2_dgrant", o_dg, (k % 2 == 1));
    end
    idle_in(); mem_rvalid = 1; step();

    // LSU write held off for three cycles while fetch starts requesting.
    for (int k = 0; k < 7; k++) begin
      idle_in();
      data_req   = (k < 4); data_we = 1; data_addr = 32'h300;
      data_wdata = 32'hCAFE; data_be = 4'b0011;
      instr_req  = (k >= 1 && k < 5); instr_addr = 32'h400;
      mem_gnt    = (k >= 3);
      mem_rvalid = (k >= 5); mem_rdata = 32'h50 + 32'(k);
      step();
      if (k < 3) begin
        check("s3_hold_addr", o_maddr, 32'h300);
        check("s3_hold_wdata", o_mwd, 32'hCAFE);
        check("s3_hold_igrant", o_ig, 1'b0);
      end
      if (k == 3) check("s3_dgrant", {o_dg, o_ig}, 2'b10);
      if (k == 4) check("s3_igrant", {o_dg, o_ig}, 2'b01);
      if (k == 5) check("s3_resp_d", {o_drv, o_irv}, 2'b10);
      if (k == 6) check("s3_resp_i", {o_drv, o_irv}, 2'b01);
    end

    // Outstanding limit, then pop and push in the same cycle.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      idle_in();
      data_req  = (k == 0) || (k >= 2 && k <= 4);
      data_addr = (k == 0) ? 32'h100 : 32'h104;
      instr_req = (k == 1); instr_addr = 32'h200;
      mem_gnt   = 1;
      mem_rvalid = (k >= 3); mem_rdata = 32'hD0 + 32'(k);
      step();
      if (k == 2) check("s4_full_block", {o_mreq, o_dg}, 2'b00);
      if (k == 3) check("s4_full_pop", {o_mreq, o_drv}, 2'b01);
      if (k == 4) check("s4_push_pop", {o_dg, o_irv}, 2'b11);
      if (k == 5) check("s4_last_resp", o_drv, 1'b1);
    end

    // Stray response with nothing outstanding.
    idle_in(); mem_rvalid = 1; mem_rdata = 32'hBAD; step();
    check("s5_err", {o_err, o_irv, o_drv}, 3'b100);
    idle_in(); step();
    check("s5_err_clear", o_err, 1'b0);

    // Reset while a request is held with one transaction outstanding.
    idle_in(); instr_req = 1; instr_addr = 32'h40; mem_gnt = 1; step();
    idle_in(); data_req = 1; data_addr = 32'h80; step();
    check("s6_holding", o_mreq, 1'b1);
    rst = 1; #1;
    check("s6_rst_now", {mem_req_o, data_gnt_o, instr_gnt_o, resp_err_o}, 4'b0000);
    check("s6_rst_addr", mem_addr_o, 32'h0);
    step();
    rst = 0; mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h5A;
    step();
    check("s6_regrant", o_dg, 1'b1);
    check("s6_stale", {o_err, o_irv, o_drv}, 3'b100);
    idle_in(); mem_rvalid = 1; mem_rdata = 32'h77; step();
    check("s6_resp", o_drv, 1'b1);

    // Randomized traffic obeying the hold-until-grant rule, with rare
    // withdrawals and rare mid-run resets.
    do_reset();
    o_ig = 0; o_dg = 0;
    for (int c = 0; c < 2000; c++) begin
      if (instr_req && o_ig) instr_req = 0;
      if (data_req && o_dg) data_req = 0;
      if (instr_req && !o_ig && $urandom_range(0, 99) == 0) instr_req = 0;
      if (data_req && !o_dg && $urandom_range(0, 99) == 0) data_req = 0;
      if (!instr_req && $urandom_range(0, 2) != 0) begin
        instr_req = 1; instr_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req && $urandom_range(0, 2) != 0) begin
        data_req = 1; data_addr = $urandom; data_we = 1'($urandom);
        data_be = 4'($urandom); data_wdata = $urandom;
      end
      rst        = ($urandom_range(0, 299) == 0);
      mem_gnt    = ($urandom_range(0, 3) != 0);
      mem_rvalid = 1'($urandom);
      mem_rdata  = $urandom;
      step();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
